// File: rtl/aq_gemac_pkg.sv
// Shared GEMAC definitions: address widths, ARP table field widths and the
// ARP cache controller state encoding.
package aq_gemac_pkg;

    localparam int unsigned IP_W  = 32;
    localparam int unsigned MAC_W = 48;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [2:0] {
        StIdle,
        StLscan,
        StLdone,
        StUscan,
        StUwrite
    } arpc_state_e;

endpackage

// File: rtl/aq_gemac_arp_cache_if.sv
// ARPC lookup handshake plus the ARP-RX learn port, as seen between the L3
// control block / ARP parser (master) and the ARP cache (slave).
interface aq_gemac_arp_cache_if;
    import aq_gemac_pkg::*;

    logic             ARPC_ENABLE;
    logic             ARPC_REQUEST;
    logic [IP_W-1:0]  ARPC_IP_ADDRESS;
    logic             ARPC_VALID;
    logic             ARPC_HIT;
    logic [MAC_W-1:0] ARPC_MAC_ADDRESS;
    logic             UPD_WE;
    logic             UPD_READY;
    logic [IP_W-1:0]  UPD_IP;
    logic [MAC_W-1:0] UPD_MAC;

    modport master (
        output ARPC_ENABLE, ARPC_REQUEST, ARPC_IP_ADDRESS, UPD_WE, UPD_IP, UPD_MAC,
        input  ARPC_VALID, ARPC_HIT, ARPC_MAC_ADDRESS, UPD_READY
    );

    modport slave (
        input  ARPC_ENABLE, ARPC_REQUEST, ARPC_IP_ADDRESS, UPD_WE, UPD_IP, UPD_MAC,
        output ARPC_VALID, ARPC_HIT, ARPC_MAC_ADDRESS, UPD_READY
    );

endinterface

// File: rtl/aq_gemac_arp_table.sv
// Flop-based ARP entry array: one indexed read port, one indexed write port,
// bulk age/expire, bulk flush and a registered count of valid entries.
module aq_gemac_arp_table
    import aq_gemac_pkg::*;
#(
    parameter int unsigned Entries = 8,
    parameter int unsigned AgeW    = 8,
    parameter int unsigned MaxAge  = 200
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [$clog2(Entries)-1:0]  rd_idx_i,
    output logic                        rd_valid_o,
    output logic [IP_W-1:0]             rd_ip_o,
    output logic [MAC_W-1:0]            rd_mac_o,
    output logic [AgeW-1:0]             rd_age_o,
    input  logic                        we_i,
    input  logic [$clog2(Entries)-1:0]  wr_idx_i,
    input  logic [IP_W-1:0]             wr_ip_i,
    input  logic [MAC_W-1:0]            wr_mac_i,
    input  logic                        age_inc_i,
    input  logic                        flush_i,
    output logic [CNT_W-1:0]            count_o
);

    localparam logic [AgeW-1:0] MaxAgeV = AgeW'(MaxAge);

    logic [Entries-1:0] valid_q;
    logic [IP_W-1:0]    ip_q   [Entries];
    logic [MAC_W-1:0]   mac_q  [Entries];
    logic [AgeW-1:0]    age_q  [Entries];
    logic [AgeW-1:0]    age_nxt[Entries];
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        rd_valid_o = valid_q[rd_idx_i];
        rd_ip_o    = ip_q[rd_idx_i];
        rd_mac_o   = mac_q[rd_idx_i];
        rd_age_o   = age_q[rd_idx_i];
        count_d    = '0;
        for (int i = 0; i < Entries; i++) begin
            age_nxt[i] = age_q[i] + 1'b1;
            count_d    = count_d + CNT_W'(valid_q[i]);
        end
    end

    // Flush beats aging beats the write; the controller never issues the latter two together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                ip_q[i]  <= '0;
                mac_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (flush_i) begin
                valid_q <= '0;
            end else if (age_inc_i) begin
                for (int i = 0; i < Entries; i++) begin
                    if (valid_q[i]) begin
                        age_q[i] <= age_nxt[i];
                        if (age_nxt[i] == MaxAgeV) valid_q[i] <= 1'b0;
                    end
                end
            end else if (we_i) begin
                valid_q[wr_idx_i] <= 1'b1;
                ip_q[wr_idx_i]    <= wr_ip_i;
                mac_q[wr_idx_i]   <= wr_mac_i;
                age_q[wr_idx_i]   <= '0;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/aq_gemac_arp_cache.sv
// ARP cache: resolves IPv4 to MAC for the L3 control block by sequential scan,
// learns from ARP RX with match/free/oldest replacement, ages on an external tick.
module aq_gemac_arp_cache
    import aq_gemac_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned AGE_W   = 8,
    parameter int unsigned MAX_AGE = 200
) (
    input  logic                 CLK,
    input  logic                 RST,
    aq_gemac_arp_cache_if.slave  arpc,
    input  logic                 AGE_TICK,
    input  logic                 FLUSH,
    output logic [CNT_W-1:0]     ENTRY_COUNT
);

    localparam int unsigned      IDX_W    = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    arpc_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [IP_W-1:0]  ip_q;
    logic [MAC_W-1:0] mac_q, res_mac_q;
    logic             hit_q, age_pend_q;
    logic             match_vld_q, free_vld_q, old_vld_q;
    logic [IDX_W-1:0] match_idx_q, free_idx_q, old_idx_q;
    logic [AGE_W-1:0] old_age_q;

    logic             rd_valid;
    logic [IP_W-1:0]  rd_ip;
    logic [MAC_W-1:0] rd_mac;
    logic [AGE_W-1:0] rd_age;
    logic             tbl_we, tbl_age, tbl_flush;
    logic [IDX_W-1:0] wr_idx;

    logic in_idle, age_go, upd_drop, req_skip, rd_hit, last_idx;
    logic take_upd, take_req;

    always_comb begin
        in_idle  = (state_q == StIdle);
        age_go   = AGE_TICK | age_pend_q;
        upd_drop = (arpc.UPD_IP == '0) | ~arpc.ARPC_ENABLE;
        req_skip = (arpc.ARPC_IP_ADDRESS == '0) | ~arpc.ARPC_ENABLE;
        // ip_q holds the lookup IP in LSCAN and the learned IP in USCAN
        rd_hit   = rd_valid & (rd_ip == ip_q);
        last_idx = (idx_q == LAST_IDX);
        wr_idx   = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (take_upd)      state_d = upd_drop ? StIdle : StUscan;
                else if (take_req) state_d = req_skip ? StLdone : StLscan;
            end
            StLscan:  if (rd_hit || last_idx) state_d = StLdone;
            StLdone:  state_d = StIdle;
            StUscan:  if (last_idx) state_d = StUwrite;
            StUwrite: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (FLUSH) state_d = StIdle;
    end

    always_comb begin
        take_upd              = in_idle & ~FLUSH & ~age_go & arpc.UPD_WE;
        take_req              = in_idle & ~FLUSH & ~age_go & ~arpc.UPD_WE & arpc.ARPC_REQUEST;
        tbl_flush             = FLUSH;
        tbl_age               = in_idle & ~FLUSH & age_go;
        tbl_we                = (state_q == StUwrite) & ~FLUSH;
        arpc.UPD_READY        = in_idle & ~RST & ~FLUSH & ~age_go;
        arpc.ARPC_VALID       = (state_q == StLdone) & ~RST;
        arpc.ARPC_HIT         = (state_q == StLdone) & ~RST & hit_q;
        arpc.ARPC_MAC_ADDRESS = res_mac_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q       <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            res_mac_q   <= '0;
            hit_q       <= 1'b0;
            age_pend_q  <= 1'b0;
            match_vld_q <= 1'b0;
            free_vld_q  <= 1'b0;
            old_vld_q   <= 1'b0;
            match_idx_q <= '0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
        end else begin
            // Ticks arriving while busy collapse into one pending application
            age_pend_q <= (age_pend_q | AGE_TICK) & ~tbl_age & ~FLUSH;

            if (in_idle) idx_q <= '0;
            else if (state_q == StLscan || state_q == StUscan) idx_q <= idx_q + 1'b1;

            if (take_upd) begin
                ip_q        <= arpc.UPD_IP;
                mac_q       <= arpc.UPD_MAC;
                match_vld_q <= 1'b0;
                free_vld_q  <= 1'b0;
                old_vld_q   <= 1'b0;
            end else if (take_req) begin
                ip_q  <= arpc.ARPC_IP_ADDRESS;
                hit_q <= 1'b0;
            end

            if (state_q == StLscan && rd_hit) begin
                hit_q     <= 1'b1;
                res_mac_q <= rd_mac;
            end

            if (state_q == StUscan) begin
                if (rd_hit && !match_vld_q) begin
                    match_vld_q <= 1'b1;
                    match_idx_q <= idx_q;
                end
                if (!rd_valid && !free_vld_q) begin
                    free_vld_q <= 1'b1;
                    free_idx_q <= idx_q;
                end
                // Strict compare keeps the lowest index among equally old entries
                if (rd_valid && (!old_vld_q || rd_age > old_age_q)) begin
                    old_vld_q <= 1'b1;
                    old_idx_q <= idx_q;
                    old_age_q <= rd_age;
                end
            end
        end
    end

    aq_gemac_arp_table #(
        .Entries (ENTRIES),
        .AgeW    (AGE_W),
        .MaxAge  (MAX_AGE)
    ) u_table (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (idx_q),
        .rd_valid_o (rd_valid),
        .rd_ip_o    (rd_ip),
        .rd_mac_o   (rd_mac),
        .rd_age_o   (rd_age),
        .we_i       (tbl_we),
        .wr_idx_i   (wr_idx),
        .wr_ip_i    (ip_q),
        .wr_mac_i   (mac_q),
        .age_inc_i  (tbl_age),
        .flush_i    (tbl_flush),
        .count_o    (ENTRY_COUNT)
    );

endmodule

// File: tb/tb_aq_gemac_arp_cache.sv
// Bench for the ARP cache: directed scenarios plus random learn/lookup/tick/flush
// traffic, checked against an array-based model of the cache contents.
module tb_aq_gemac_arp_cache;

    localparam int unsigned ENTRIES = 8;
    localparam int unsigned AGE_W   = 8;
    localparam int unsigned MAX_AGE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       age_tick = 1'b0;
    logic       flush = 1'b0;
    logic       en = 1'b1;
    logic [5:0] entry_count;

    aq_gemac_arp_cache_if arpc_if ();

    aq_gemac_arp_cache #(
        .ENTRIES (ENTRIES),
        .AGE_W   (AGE_W),
        .MAX_AGE (MAX_AGE)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .arpc        (arpc_if),
        .AGE_TICK    (age_tick),
        .FLUSH       (flush),
        .ENTRY_COUNT (entry_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the cache contents
    bit          m_valid [ENTRIES];
    logic [31:0] m_ip    [ENTRIES];
    logic [47:0] m_mac   [ENTRIES];
    int          m_age   [ENTRIES];
    logic [47:0] m_last_mac = '0;
    int          cnt_at_valid = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ip[i]    = '0;
            m_mac[i]   = '0;
            m_age[i]   = 0;
        end
        m_last_mac = '0;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic int model_find(input logic [31:0] ip);
        int k = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (k < 0 && m_valid[i] && m_ip[i] == ip) k = i;
        return k;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < ENTRIES; i++) c += int'(m_valid[i]);
        return c;
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < ENTRIES; i++) begin
            if (m_valid[i]) begin
                m_age[i]++;
                if (m_age[i] == MAX_AGE) m_valid[i] = 1'b0;
            end
        end
    endfunction

    function automatic void model_learn(input logic [31:0] ip, input logic [47:0] mac);
        int t = model_find(ip);
        if (t < 0)
            for (int i = 0; i < ENTRIES; i++) if (t < 0 && !m_valid[i]) t = i;
        if (t < 0) begin
            t = 0;
            for (int i = 1; i < ENTRIES; i++) if (m_age[i] > m_age[t]) t = i;
        end
        m_valid[t] = 1'b1;
        m_ip[t]    = ip;
        m_mac[t]   = mac;
        m_age[t]   = 0;
    endfunction

    function automatic logic [31:0] pool_ip(input int unsigned k);
        return (k == 0) ? 32'h0 : 32'hC0A8_0100 + k;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_count();
        repeat (2) cycle();
        check("entry_count", 64'(entry_count), 64'(model_count()));
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        int  n = 0;
        int  w = 0;
        bit  drop;
        while (!arpc_if.UPD_READY && w < 8) begin
            cycle();
            w++;
        end
        check("upd_ready", 64'(arpc_if.UPD_READY), 64'd1);
        drop = (ip == 0) || !en;
        arpc_if.UPD_WE  = 1'b1;
        arpc_if.UPD_IP  = ip;
        arpc_if.UPD_MAC = mac;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        arpc_if.UPD_WE = 1'b0;
        while (!arpc_if.UPD_READY && n < 64) begin
            cycle();
            n++;
        end
        check("upd_latency", 64'(n), drop ? 64'd1 : 64'(ENTRIES + 2));
        if (!drop) model_learn(ip, mac);
    endtask

    task automatic lookup(input logic [31:0] ip, input int tick_at);
        int k = model_find(ip);
        bit skip = (ip == 0) || !en;
        bit exp_hit = !skip && (k >= 0);
        int exp_lat = skip ? 1 : (k >= 0 ? k + 2 : ENTRIES + 1);
        int n = 0;
        bit seen = 1'b0;
        arpc_if.ARPC_REQUEST    = 1'b1;
        arpc_if.ARPC_IP_ADDRESS = ip;
        while (!seen && n < 64) begin
            cycle();
            n++;
            age_tick = (n == tick_at);
            if (arpc_if.ARPC_VALID) seen = 1'b1;
        end
        age_tick = 1'b0;
        cnt_at_valid = int'(entry_count);
        check("lk_valid_seen", 64'(seen), 64'd1);
        check("lk_latency", 64'(n), 64'(exp_lat));
        check("lk_hit", 64'(arpc_if.ARPC_HIT), 64'(exp_hit));
        if (exp_hit) m_last_mac = m_mac[k];
        check("lk_mac", 64'(arpc_if.ARPC_MAC_ADDRESS), 64'(m_last_mac));
        arpc_if.ARPC_REQUEST = 1'b0;
        cycle();
        check("lk_pulse_width", 64'(arpc_if.ARPC_VALID), 64'd0);
        if (tick_at > 0) model_tick();
    endtask

    task automatic tick();
        age_tick = 1'b1;
        cycle();
        age_tick = 1'b0;
        model_tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        model_flush();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          op;
        int          n;
        bit          seen;
        logic [47:0] rmac;

        arpc_if.ARPC_ENABLE     = 1'b1;
        arpc_if.ARPC_REQUEST    = 1'b0;
        arpc_if.ARPC_IP_ADDRESS = '0;
        arpc_if.UPD_WE          = 1'b0;
        arpc_if.UPD_IP          = '0;
        arpc_if.UPD_MAC         = '0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready_low", 64'(arpc_if.UPD_READY), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_ready_high", 64'(arpc_if.UPD_READY), 64'd1);
        check("rst_valid", 64'(arpc_if.ARPC_VALID), 64'd0);
        check("rst_hit", 64'(arpc_if.ARPC_HIT), 64'd0);
        check("rst_mac", 64'(arpc_if.ARPC_MAC_ADDRESS), 64'd0);
        check("rst_count", 64'(entry_count), 64'd0);
        @(negedge clk);

        // Learn then hit at index 0; unknown IP misses after full scan
        learn(32'hC0A8_0102, 48'h0011_2233_4455);
        lookup(32'hC0A8_0102, 0);
        check("first_hit_mac", 64'(arpc_if.ARPC_MAC_ADDRESS), 64'h0011_2233_4455);
        lookup(32'hC0A8_0103, 0);

        // Re-learning the same IP updates in place
        learn(32'hC0A8_0102, 48'h0011_2233_4466);
        check_count();
        lookup(32'hC0A8_0102, 0);
        check("relearn_mac", 64'(arpc_if.ARPC_MAC_ADDRESS), 64'h0011_2233_4466);

        // Replacement of the oldest entry (index 3)
        do_flush();
        for (int i = 0; i < ENTRIES; i++) learn(32'h0A00_0001 + i, 48'hAA00_0000_0000 + i);
        tick();
        for (int i = 0; i < ENTRIES; i++)
            if (i != 3) learn(32'h0A00_0001 + i, 48'hBB00_0000_0000 + i);
        learn(32'h0A00_0099, 48'hCC00_0000_0099);
        check_count();
        check("repl_count", 64'(entry_count), 64'd8);
        lookup(32'h0A00_0004, 0);
        lookup(32'h0A00_0099, 0);

        // Expiry after MAX_AGE ticks, and a tick deferred past an in-flight lookup
        do_flush();
        learn(32'hC0A8_0102, 48'h0011_2233_4455);
        check_count();
        tick();
        tick();
        check_count();
        lookup(32'hC0A8_0102, 0);
        learn(32'hC0A8_0102, 48'h0011_2233_4455);
        tick();
        lookup(32'hC0A8_0103, 4);
        check("tick_deferred_count", 64'(cnt_at_valid), 64'd1);
        check_count();

        // FLUSH mid-LSCAN with REQUEST held: aborted, then re-served as a miss
        learn(32'hC0A8_0201, 48'h0000_0000_0201);
        learn(32'hC0A8_0202, 48'h0000_0000_0202);
        arpc_if.ARPC_REQUEST    = 1'b1;
        arpc_if.ARPC_IP_ADDRESS = 32'hC0A8_0203;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (arpc_if.ARPC_VALID) seen = 1'b1;
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        if (arpc_if.ARPC_VALID) seen = 1'b1;
        model_flush();
        check("flush_no_valid", 64'(seen), 64'd0);
        n = 0;
        while (!arpc_if.ARPC_VALID && n < 64) begin
            cycle();
            n++;
        end
        check("flush_reserve_lat", 64'(n), 64'(ENTRIES + 1));
        check("flush_reserve_hit", 64'(arpc_if.ARPC_HIT), 64'd0);
        check("flush_count", 64'(entry_count), 64'd0);
        arpc_if.ARPC_REQUEST = 1'b0;
        cycle();

        // RST mid-USCAN
        learn(32'hC0A8_0301, 48'h1234_5678_9ABC);
        lookup(32'hC0A8_0301, 0);
        arpc_if.UPD_WE  = 1'b1;
        arpc_if.UPD_IP  = 32'hC0A8_0302;
        arpc_if.UPD_MAC = 48'h0000_0000_0302;
        cycle();
        arpc_if.UPD_WE = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check("rstmid_valid", 64'(arpc_if.ARPC_VALID), 64'd0);
        check("rstmid_hit", 64'(arpc_if.ARPC_HIT), 64'd0);
        check("rstmid_mac", 64'(arpc_if.ARPC_MAC_ADDRESS), 64'd0);
        check("rstmid_count", 64'(entry_count), 64'd0);
        check("rstmid_ready", 64'(arpc_if.UPD_READY), 64'd0);
        rst = 1'b0;
        model_reset();
        #1;
        check("rstmid_ready_after", 64'(arpc_if.UPD_READY), 64'd1);
        @(negedge clk);
        lookup(32'hC0A8_0301, 0);

        // Random traffic
        for (int it = 0; it < 200; it++) begin
            en = ($urandom_range(0, 19) != 0);
            arpc_if.ARPC_ENABLE = en;
            op = int'($urandom_range(0, 99));
            if (op < 40) begin
                rmac = {16'($urandom()), $urandom()};
                learn(pool_ip($urandom_range(0, 11)), rmac);
            end else if (op < 75) begin
                lookup(pool_ip($urandom_range(0, 11)), 0);
            end else if (op < 93) begin
                tick();
            end else if (op < 97) begin
                do_flush();
            end else begin
                lookup(pool_ip($urandom_range(1, 11)), int'($urandom_range(1, 3)));
            end
            check_count();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aq_gemac_arp_cache.md
Name: aq_gemac_arp_cache

Overview:
- ARP cache that resolves IPv4 addresses to MAC addresses for the L3 control block.
- Serves the ARPC_* lookup handshake used by the L3 control block.
- Learns entries from the ARP receive path through a separate update port.
- Ages entries on an external tick. Sits beside the L3 control block, between the ARP RX parser and the TX header builder.

Parameters:
- ENTRIES, 8, number of cache entries; power of two, 2..32.
- AGE_W, 8, width of each entry's age counter.
- MAX_AGE, 8'd200, age in ticks at which an entry is invalidated; must be at least 1.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- ARPC_ENABLE  in  1  cache enable; 0 = every lookup misses, updates dropped
- ARPC_REQUEST  in  1  lookup request; level, held until ARPC_VALID
- ARPC_IP_ADDRESS  in  32  IP to resolve; stable while ARPC_REQUEST=1
- ARPC_VALID  out  1  one-cycle pulse, lookup result valid
- ARPC_HIT  out  1  qualified by ARPC_VALID; 1 = entry found
- ARPC_MAC_ADDRESS  out  48  resolved MAC, qualified by ARPC_VALID and ARPC_HIT
- UPD_WE  in  1  learn pulse, accepted only when UPD_READY=1
- UPD_READY  out  1  block is in IDLE and UPD_WE will be taken
- UPD_IP  in  32  learned IP
- UPD_MAC  in  48  learned MAC
- AGE_TICK  in  1  single-cycle aging strobe
- FLUSH  in  1  invalidate all entries
- ENTRY_COUNT  out  6  number of valid entries

Behaviour:
- Storage: ENTRIES × {valid, ip[31:0], mac[47:0], age[AGE_W-1:0]} in flops.
- Reset: all valid bits = 0. ARPC_VALID = 0, ARPC_HIT = 0, ARPC_MAC_ADDRESS = 0, UPD_READY = 0 during reset and 1 in the first cycle after it, ENTRY_COUNT = 0. State = IDLE.
- States: IDLE, LSCAN, LDONE, USCAN, UWRITE.
- IDLE priority order: FLUSH > AGE (tick or pending tick) > UPD_WE > ARPC_REQUEST. Only one action is taken per cycle.
- Lookup:
  - IDLE with ARPC_REQUEST=1 and nothing of higher priority: latch the IP, idx=0, go to LSCAN.
  - LSCAN compares entry[idx] each cycle. On valid && ip match: latch MAC, HIT=1, go to LDONE. After the last idx with no match: HIT=0, go to LDONE.
  - LDONE: ARPC_VALID=1 for one cycle, then IDLE.
  - A hit at index k gives ARPC_VALID k+2 cycles after the request is taken. A miss gives ARPC_VALID ENTRIES+1 cycles after.
  - ARPC_MAC_ADDRESS holds its value until the next ARPC_VALID.
  - ARPC_IP_ADDRESS=0, or ARPC_ENABLE=0: LDONE directly, miss, latency 1.
  - The requester must deassert ARPC_REQUEST in the cycle after ARPC_VALID. If it is still high in IDLE, that is a new lookup.
- Update:
  - UPD_WE is taken in IDLE and the IP/MAC are latched. UPD_READY=0 outside IDLE.
  - UPD_IP=0 or ARPC_ENABLE=0: the pulse is accepted and dropped.
  - USCAN walks all entries and records:
    - first match index;
    - first invalid index;
    - oldest valid index (largest age, lowest index on ties).
  - UWRITE target is the match if there is one, else the first invalid, else the oldest. Write valid=1, ip, mac, age=0, then IDLE.
  - Update latency is ENTRIES+2 cycles. An update never creates a duplicate IP.
- Aging:
  - An AGE_TICK seen in any state sets a pending flag; multiple ticks while busy collapse to one.
  - Applying the tick in IDLE takes one cycle: every valid entry's age increments, and an entry whose new age equals MAX_AGE is cleared to valid=0. Clear the pending flag.
- Flush:
  - FLUSH=1 in any state clears all valid bits and the pending tick, and returns to IDLE next cycle.
  - An in-flight lookup is aborted with no ARPC_VALID. If the requester is still holding REQUEST it is re-served afterward and misses.
  - An in-flight update is discarded.
- ENTRY_COUNT is a registered popcount of the valid bits and updates the cycle after any change.
- The ARPC_HIT/ARPC_VALID relationship holds only when ARPC_VALID=1; ARPC_HIT is don't-care otherwise and is driven 0.

Decomposition:
- Shared package aq_gemac_pkg holds the state encodings, IP_W=32, MAC_W=48, and the ARP table-entry field widths.
- Natural sub-module: aq_gemac_arp_table. It holds the entry array with one indexed read port, one indexed write port, a bulk age-increment/invalidate operation, a bulk flush and the valid-bit popcount.
- The FSM stays in aq_gemac_arp_cache.

Test Plan:
- Learn IP 0xC0A80102 → MAC 0x001122334455, then look it up → ARPC_VALID 2 cycles after the request (index 0), HIT=1, MAC=0x001122334455. Look up 0xC0A80103 → VALID after 9 cycles (ENTRIES=8), HIT=0.
- Learn 0xC0A80102 twice with MACs 0x…55 then 0x…66 → ENTRY_COUNT=1, lookup returns 0x…66.
- Fill 8 entries, give entry 3 the largest age via an AGE_TICK after selective refreshes, learn a 9th IP → entry 3 replaced, ENTRY_COUNT stays 8, the old IP in entry 3 misses.
- MAX_AGE=2: learn, apply 2 AGE_TICKs → ENTRY_COUNT 1→0, lookup misses. Assert AGE_TICK during an LSCAN → the tick is applied after LDONE.
- Assert FLUSH mid-LSCAN with REQUEST held → no VALID pulse, ENTRY_COUNT=0, then VALID with HIT=0. Assert RST mid-USCAN → all outputs at their reset values next cycle and the table is empty.
